// File: rtl/seq_detect_pkg.sv
// Shared constants, mode encoding and length clamp for the serial pattern detector.
package seq_detect_pkg;

  localparam logic [7:0]  SD_DEF_PAT = 8'b0000_0101;
  localparam int unsigned SD_DEF_LEN = 3;

  typedef enum logic {
    NONOVERLAP = 1'b0,
    OVERLAP    = 1'b1
  } mode_e;

  // Zero length becomes 1; anything beyond the window becomes max_len.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) begin
      return 1;
    end else if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/seq_detect_n_sat_counter.sv
// Saturating event counter with synchronous clear and registered saturation flag.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  // Clear wins over the stored value but still counts an event arriving in the same cycle.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? ONE : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
    sat_d = &count_d;
  end

  // Count and flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/seq_detect_n.sv
// Runtime-programmable serial pattern detector with overlap control and match counter.
module seq_detect_n
  import seq_detect_pkg::*;
#(
  parameter int unsigned          MAX_LEN = 8,
  parameter int unsigned          LEN_W   = 4,
  parameter int unsigned          CNT_W   = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PAT = MAX_LEN'(SD_DEF_PAT),
  parameter int unsigned          DEF_LEN = SD_DEF_LEN
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iEN,
  input  logic               iIN,
  input  logic               iLOAD,
  input  logic [MAX_LEN-1:0] iPAT,
  input  logic [LEN_W-1:0]   iLEN,
  input  logic               iOVERLAP,
  input  logic               iCLR_CNT,
  output logic               oMATCH,
  output logic [CNT_W-1:0]   oCOUNT,
  output logic               oSAT
);

  localparam logic [LEN_W:0]   ONE_X = (LEN_W+1)'(1);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic               match_q, match_d;

  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_inc;
  logic               hit;

  // Candidate window is history plus the incoming bit; only the low len_q bits are compared.
  always_comb begin
    win = {hist_q, iIN};
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len_q));
    end
    fill_inc = {1'b0, fill_q} + ONE_X;
    hit = (((win ^ pat_q) & mask) == '0) && (fill_inc >= {1'b0, len_q});
  end

  // Next-state: load has priority, then qualified sample; otherwise hold.
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    fill_d  = fill_q;
    hist_d  = hist_q;
    match_d = 1'b0;
    if (iLOAD) begin
      pat_d  = iPAT;
      len_d  = LEN_W'(clamp_len(32'(iLEN), MAX_LEN));
      hist_d = '0;
      fill_d = '0;
    end else if (iEN) begin
      hist_d  = win[MAX_LEN-2:0];
      match_d = hit;
      if (hit && (mode_e'(iOVERLAP) == NONOVERLAP)) begin
        fill_d = '0;
      end else if (fill_q < len_q) begin
        fill_d = fill_q + ONE_L;
      end
    end
  end

  // Detector state and registered match pulse.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      pat_q   <= DEF_PAT;
      len_q   <= LEN_W'(DEF_LEN);
      fill_q  <= '0;
      hist_q  <= '0;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      match_q <= match_d;
    end
  end

  // Counter steps on the same edge that raises oMATCH, so both reflect a match together.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i   (iCLK),
    .rst_ni  (iRST),
    .inc_i   (match_d),
    .clr_i   (iCLR_CNT),
    .count_o (oCOUNT),
    .sat_o   (oSAT)
  );

  assign oMATCH = match_q;

endmodule

// File: tb/tb_seq_detect_n.sv
// Directed self-checking bench for seq_detect_n.
module tb_seq_detect_n;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b0;
  logic       iEN = 1'b0;
  logic       iIN = 1'b0;
  logic       iLOAD = 1'b0;
  logic [7:0] iPAT = '0;
  logic [3:0] iLEN = '0;
  logic       iOVERLAP = 1'b1;
  logic       iCLR_CNT = 1'b0;

  logic       oMATCH, oSAT;
  logic [7:0] oCOUNT;
  logic       oMATCH2, oSAT2;
  logic [1:0] oCOUNT2;

  int errors = 0;
  int checks = 0;

  always #5 iCLK = ~iCLK;

  seq_detect_n u_dut (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iIN(iIN), .iLOAD(iLOAD),
    .iPAT(iPAT), .iLEN(iLEN), .iOVERLAP(iOVERLAP), .iCLR_CNT(iCLR_CNT),
    .oMATCH(oMATCH), .oCOUNT(oCOUNT), .oSAT(oSAT)
  );

  seq_detect_n #(.CNT_W(2)) u_dut2 (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iIN(iIN), .iLOAD(iLOAD),
    .iPAT(iPAT), .iLEN(iLEN), .iOVERLAP(iOVERLAP), .iCLR_CNT(iCLR_CNT),
    .oMATCH(oMATCH2), .oCOUNT(oCOUNT2), .oSAT(oSAT2)
  );

  task automatic cycle(input logic en, input logic in);
    iEN = en;
    iIN = in;
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    iRST = 1'b0;
    @(posedge iCLK);
    #1;
    iRST = 1'b1;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len);
    iLOAD = 1'b1;
    iPAT  = pat;
    iLEN  = len;
    cycle(1'b1, 1'b1);
    iLOAD = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b0;
    @(posedge iCLK);
    #1;
    checks++;
    if (oMATCH !== 1'b0) begin errors++; $display("FAIL reset_match: got %b expected 0", oMATCH); end
    checks++;
    if (oCOUNT !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", oCOUNT); end
    checks++;
    if (oSAT !== 1'b0 || oSAT2 !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b/%b expected 0/0", oSAT, oSAT2); end
    iRST = 1'b1;
  endtask

  task automatic test_overlap();
    bit s[5] = '{1, 0, 1, 0, 1};
    bit e[5] = '{0, 0, 1, 0, 1};
    do_reset();
    iOVERLAP = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, s[i]);
      checks++;
      if (oMATCH !== e[i]) begin errors++; $display("FAIL ovl_match bit%0d: got %b expected %b", i+1, oMATCH, e[i]); end
    end
    checks++;
    if (oCOUNT !== 8'd2) begin errors++; $display("FAIL ovl_count: got %0d expected 2", oCOUNT); end
  endtask

  task automatic test_nonoverlap();
    bit s[5] = '{1, 0, 1, 0, 1};
    bit e[5] = '{0, 0, 1, 0, 0};
    do_reset();
    iOVERLAP = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, s[i]);
      checks++;
      if (oMATCH !== e[i]) begin errors++; $display("FAIL novl_match bit%0d: got %b expected %b", i+1, oMATCH, e[i]); end
    end
    checks++;
    if (oCOUNT !== 8'd1) begin errors++; $display("FAIL novl_count: got %0d expected 1", oCOUNT); end
    iOVERLAP = 1'b1;
  endtask

  task automatic test_load_pattern();
    bit s[7] = '{1, 1, 0, 1, 1, 0, 1};
    bit e[7] = '{0, 0, 0, 1, 0, 0, 1};
    do_reset();
    load(8'b0000_1101, 4'd4);
    checks++;
    if (oMATCH !== 1'b0) begin errors++; $display("FAIL load_cycle_match: got %b expected 0", oMATCH); end
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, s[i]);
      checks++;
      if (oMATCH !== e[i]) begin errors++; $display("FAIL pat4_match bit%0d: got %b expected %b", i+1, oMATCH, e[i]); end
    end
    // Same stream with a two-cycle enable gap (garbage on iIN) after bit 5.
    load(8'b0000_1101, 4'd4);
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin
        for (int g = 0; g < 2; g++) begin
          cycle(1'b0, 1'b0);
          checks++;
          if (oMATCH !== 1'b0) begin errors++; $display("FAIL gap_match g%0d: got %b expected 0", g, oMATCH); end
        end
      end
      cycle(1'b1, s[i]);
      checks++;
      if (oMATCH !== e[i]) begin errors++; $display("FAIL gap_match bit%0d: got %b expected %b", i+1, oMATCH, e[i]); end
    end
    checks++;
    if (oCOUNT !== 8'd4) begin errors++; $display("FAIL load_keeps_count: got %0d expected 4", oCOUNT); end
  endtask

  task automatic test_len_clamp();
    bit s1[3] = '{1, 0, 1};
    bit s8[8] = '{1, 0, 1, 0, 0, 1, 1, 0};
    logic exp;
    do_reset();
    load(8'b0000_0001, 4'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, s1[i]);
      checks++;
      if (oMATCH !== s1[i]) begin errors++; $display("FAIL len0_match bit%0d: got %b expected %b", i+1, oMATCH, s1[i]); end
    end
    load(8'b1010_0110, 4'd15);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, s8[i]);
      exp = (i == 7);
      checks++;
      if (oMATCH !== exp) begin errors++; $display("FAIL len15_match bit%0d: got %b expected %b", i+1, oMATCH, exp); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load(8'b0000_0001, 4'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1);
      checks++;
      if (oMATCH !== 1'b1) begin errors++; $display("FAIL b2b_match bit%0d: got %b expected 1", i+1, oMATCH); end
    end
    checks++;
    if (oCOUNT !== 8'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", oCOUNT); end
  endtask

  task automatic test_saturation();
    logic [1:0] ec[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic       es[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    iOVERLAP = 1'b1;
    cycle(1'b1, 1'b1);
    for (int m = 0; m < 5; m++) begin
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      checks++;
      if (oCOUNT2 !== ec[m] || oSAT2 !== es[m]) begin
        errors++;
        $display("FAIL sat_count m%0d: got %0d/%b expected %0d/%b", m+1, oCOUNT2, oSAT2, ec[m], es[m]);
      end
    end
    cycle(1'b1, 1'b0);
    iCLR_CNT = 1'b1;
    cycle(1'b1, 1'b1);
    iCLR_CNT = 1'b0;
    checks++;
    if (oMATCH2 !== 1'b1 || oCOUNT2 !== 2'd1 || oSAT2 !== 1'b0) begin
      errors++;
      $display("FAIL clr_with_match: got m=%b c=%0d s=%b expected m=1 c=1 s=0", oMATCH2, oCOUNT2, oSAT2);
    end
    iCLR_CNT = 1'b1;
    cycle(1'b1, 1'b0);
    iCLR_CNT = 1'b0;
    checks++;
    if (oCOUNT2 !== 2'd0 || oCOUNT !== 8'd0) begin
      errors++;
      $display("FAIL clr_no_match: got %0d/%0d expected 0/0", oCOUNT2, oCOUNT);
    end
  endtask

  task automatic test_reset_midstream();
    bit s[4] = '{1, 1, 0, 1};
    bit e[4] = '{0, 0, 0, 1};
    bit r[3] = '{1, 0, 1};
    bit er[3] = '{0, 0, 1};
    do_reset();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    iRST = 1'b0;
    #1;
    checks++;
    if (oMATCH !== 1'b0 || oCOUNT !== 8'd0) begin errors++; $display("FAIL async_reset: got m=%b c=%0d expected m=0 c=0", oMATCH, oCOUNT); end
    @(posedge iCLK);
    #1;
    iRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, s[i]);
      checks++;
      if (oMATCH !== e[i]) begin errors++; $display("FAIL post_rst_match bit%0d: got %b expected %b", i+1, oMATCH, e[i]); end
    end
    load(8'b0000_1101, 4'd4);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, r[i]);
      checks++;
      if (oMATCH !== er[i]) begin errors++; $display("FAIL cfg_restore bit%0d: got %b expected %b", i+1, oMATCH, er[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_load_pattern();
    test_len_clamp();
    test_back_to_back();
    test_saturation();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
